// File: rtl/xfft_frame_sequencer_if.sv
// Datapath-side handshakes of the xFFT frame sequencer: config channel,
// mover start/done strobes and the core's framing-error events.
interface xfft_frame_sequencer_if #(
    parameter int CFG_W = 24
);
    logic             CFG_TVALID;
    logic             CFG_TREADY;
    logic [CFG_W-1:0] CFG_TDATA;
    logic             M2S_GO;
    logic             M2S_DONE;
    logic             S2M_GO;
    logic             S2M_DONE;
    logic             EVT_TLAST_UNEXPECTED;
    logic             EVT_TLAST_MISSING;

    modport master (
        output CFG_TVALID, CFG_TDATA, M2S_GO, S2M_GO,
        input  CFG_TREADY, M2S_DONE, S2M_DONE, EVT_TLAST_UNEXPECTED, EVT_TLAST_MISSING
    );

    modport slave (
        input  CFG_TVALID, CFG_TDATA, M2S_GO, S2M_GO,
        output CFG_TREADY, M2S_DONE, S2M_DONE, EVT_TLAST_UNEXPECTED, EVT_TLAST_MISSING
    );
endinterface

// File: rtl/xfft_frame_sequencer.sv
// Run sequencer for the xFFT datapath: one config word, then N frames of S2M/M2S moves.
// Optional per-frame watchdog enabled by defining XFFT_FRAME_SEQUENCER_TIMEOUT_EN.
module xfft_frame_sequencer #(
    parameter int CFG_W     = 24,
    parameter int SCALE_W   = 10,
    parameter int MIN_NFFT  = 3,
    parameter int MAX_NFFT  = 10,
    parameter int TIMEOUT_W = 24
) (
    input  logic                 SYS_CLK,
    input  logic                 SYS_RST_N,
    input  logic                 CTL_GO,
    input  logic                 CTL_ABORT,
    input  logic [4:0]           CTL_NFFT,
    input  logic                 CTL_FWD_INV,
    input  logic [SCALE_W-1:0]   CTL_SCALE,
    input  logic [15:0]          CTL_FRAMES,
`ifdef XFFT_FRAME_SEQUENCER_TIMEOUT_EN
    input  logic [TIMEOUT_W-1:0] CTL_TIMEOUT,
`endif
    output logic                 STS_BUSY,
    output logic                 STS_DONE,
    output logic                 STS_ERR,
    output logic [2:0]           STS_ERR_CODE,
    output logic [15:0]          STS_FRAME_CNT,
    output logic                 IRQ,
    xfft_frame_sequencer_if.master dp
);
    typedef enum logic [1:0] {S_IDLE, S_CFG, S_LAUNCH, S_WAIT} state_t;

    localparam logic [4:0] NFFT_LO = 5'(MIN_NFFT);
    localparam logic [4:0] NFFT_HI = 5'(MAX_NFFT);

    state_t             state, state_next;
    logic [4:0]         nfft_r;
    logic               fwd_inv_r;
    logic [SCALE_W-1:0] scale_r;
    logic [15:0]        frames_r;
    logic               m2s_seen_r, s2m_seen_r;
    logic               done_r, err_r, irq_r;
    logic [2:0]         err_code_r;
    logic [15:0]        frame_cnt_r;

    logic       start_req, args_ok, evt_any, both_done, more_frames, wd_expire;
    logic [2:0] evt_code;

    assign start_req   = CTL_GO && !CTL_ABORT;
    assign args_ok     = (CTL_NFFT >= NFFT_LO) && (CTL_NFFT <= NFFT_HI) && (CTL_FRAMES != 16'd0);
    assign evt_any     = dp.EVT_TLAST_UNEXPECTED || dp.EVT_TLAST_MISSING;
    assign evt_code    = dp.EVT_TLAST_UNEXPECTED ? 3'd1 : 3'd2;
    // A done pulse arriving in the same cycle as the other latch counts immediately.
    assign both_done   = (m2s_seen_r || dp.M2S_DONE) && (s2m_seen_r || dp.S2M_DONE);
    assign more_frames = ({1'b0, frame_cnt_r} + 17'd1) < {1'b0, frames_r};

`ifdef XFFT_FRAME_SEQUENCER_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] timeout_r, wd_cnt;

    assign wd_expire = (timeout_r != '0) && (wd_cnt == TIMEOUT_W'(1));

    // Watchdog reloads in every LAUNCH and counts down the cycles spent in WAIT.
    always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
        if (!SYS_RST_N) begin
            timeout_r <= '0;
            wd_cnt    <= '0;
        end else begin
            if (state == S_IDLE && start_req)
                timeout_r <= CTL_TIMEOUT;
            if (state == S_LAUNCH)
                wd_cnt <= timeout_r;
            else if (state == S_WAIT && wd_cnt != '0)
                wd_cnt <= wd_cnt - TIMEOUT_W'(1);
        end
    end
`else
    assign wd_expire = 1'b0;
`endif

    always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
        if (!SYS_RST_N)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    // Abort beats errors, errors beat frame completion, completion beats the watchdog.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (start_req && args_ok) state_next = S_CFG;
            S_CFG:    if (CTL_ABORT) state_next = S_IDLE;
                      else if (dp.CFG_TREADY) state_next = S_LAUNCH;
            S_LAUNCH: if (CTL_ABORT || evt_any) state_next = S_IDLE;
                      else state_next = S_WAIT;
            S_WAIT:   if (CTL_ABORT || evt_any) state_next = S_IDLE;
                      else if (both_done) state_next = more_frames ? S_LAUNCH : S_IDLE;
                      else if (wd_expire) state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
        if (!SYS_RST_N) begin
            nfft_r      <= '0;
            fwd_inv_r   <= 1'b0;
            scale_r     <= '0;
            frames_r    <= '0;
            m2s_seen_r  <= 1'b0;
            s2m_seen_r  <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
            err_code_r  <= '0;
            frame_cnt_r <= '0;
            irq_r       <= 1'b0;
        end else begin
            irq_r <= 1'b0;
            case (state)
                S_IDLE: if (start_req) begin
                    nfft_r      <= CTL_NFFT;
                    fwd_inv_r   <= CTL_FWD_INV;
                    scale_r     <= CTL_SCALE;
                    frames_r    <= CTL_FRAMES;
                    done_r      <= 1'b0;
                    err_r       <= 1'b0;
                    err_code_r  <= 3'd0;
                    frame_cnt_r <= 16'd0;
                    if (!args_ok) begin
                        err_r      <= 1'b1;
                        err_code_r <= 3'd3;
                        irq_r      <= 1'b1;
                    end
                end
                S_LAUNCH: begin
                    m2s_seen_r <= 1'b0;
                    s2m_seen_r <= 1'b0;
                    if (!CTL_ABORT && evt_any) begin
                        err_r      <= 1'b1;
                        err_code_r <= evt_code;
                        irq_r      <= 1'b1;
                    end
                end
                S_WAIT: if (!CTL_ABORT) begin
                    m2s_seen_r <= m2s_seen_r || dp.M2S_DONE;
                    s2m_seen_r <= s2m_seen_r || dp.S2M_DONE;
                    if (evt_any) begin
                        err_r      <= 1'b1;
                        err_code_r <= evt_code;
                        irq_r      <= 1'b1;
                    end else if (both_done) begin
                        if (frame_cnt_r != 16'hFFFF)
                            frame_cnt_r <= frame_cnt_r + 16'd1;
                        if (!more_frames) begin
                            done_r <= 1'b1;
                            irq_r  <= 1'b1;
                        end
                    end else if (wd_expire) begin
                        err_r      <= 1'b1;
                        err_code_r <= 3'd4;
                        irq_r      <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        dp.CFG_TDATA                 = '0;
        dp.CFG_TDATA[4:0]            = nfft_r;
        dp.CFG_TDATA[8]              = fwd_inv_r;
        dp.CFG_TDATA[8+SCALE_W:9]    = scale_r;
        dp.CFG_TVALID                = (state == S_CFG);
        dp.M2S_GO                    = (state == S_LAUNCH);
        dp.S2M_GO                    = (state == S_LAUNCH);
        STS_BUSY                     = (state != S_IDLE);
        STS_DONE                     = done_r;
        STS_ERR                      = err_r;
        STS_ERR_CODE                 = err_code_r;
        STS_FRAME_CNT                = frame_cnt_r;
        IRQ                          = irq_r;
    end
endmodule

// File: tb/tb_xfft_frame_sequencer.sv
// Randomized self-checking bench for xfft_frame_sequencer; status and event counts
// are predicted from run-level rules (frames, error frame, handshake delays).
`timescale 1ns/1ps
module tb_xfft_frame_sequencer;
    localparam int CFG_W   = 24;
    localparam int SCALE_W = 10;

    logic               SYS_CLK = 1'b0;
    logic               SYS_RST_N = 1'b0;
    logic               CTL_GO = 1'b0;
    logic               CTL_ABORT = 1'b0;
    logic [4:0]         CTL_NFFT = '0;
    logic               CTL_FWD_INV = 1'b0;
    logic [SCALE_W-1:0] CTL_SCALE = '0;
    logic [15:0]        CTL_FRAMES = '0;
`ifdef XFFT_FRAME_SEQUENCER_TIMEOUT_EN
    logic [23:0]        CTL_TIMEOUT = '0;
`endif
    logic               STS_BUSY, STS_DONE, STS_ERR, IRQ;
    logic [2:0]         STS_ERR_CODE;
    logic [15:0]        STS_FRAME_CNT;

    int checks = 0;
    int errors = 0;
    int n_cfg_valid = 0, n_cfg_hs = 0, n_m2s_go = 0, n_s2m_go = 0, n_irq = 0, n_busy = 0;

    xfft_frame_sequencer_if #(.CFG_W(CFG_W)) dp ();

    xfft_frame_sequencer dut (
        .SYS_CLK       (SYS_CLK),
        .SYS_RST_N     (SYS_RST_N),
        .CTL_GO        (CTL_GO),
        .CTL_ABORT     (CTL_ABORT),
        .CTL_NFFT      (CTL_NFFT),
        .CTL_FWD_INV   (CTL_FWD_INV),
        .CTL_SCALE     (CTL_SCALE),
        .CTL_FRAMES    (CTL_FRAMES),
`ifdef XFFT_FRAME_SEQUENCER_TIMEOUT_EN
        .CTL_TIMEOUT   (CTL_TIMEOUT),
`endif
        .STS_BUSY      (STS_BUSY),
        .STS_DONE      (STS_DONE),
        .STS_ERR       (STS_ERR),
        .STS_ERR_CODE  (STS_ERR_CODE),
        .STS_FRAME_CNT (STS_FRAME_CNT),
        .IRQ           (IRQ),
        .dp            (dp)
    );

    always #5 SYS_CLK = ~SYS_CLK;

    // Event counters sampled mid-cycle, when every DUT output and bench input is stable.
    always @(negedge SYS_CLK) begin
        if (dp.CFG_TVALID) n_cfg_valid++;
        if (dp.CFG_TVALID && dp.CFG_TREADY) n_cfg_hs++;
        if (dp.M2S_GO) n_m2s_go++;
        if (dp.S2M_GO) n_s2m_go++;
        if (IRQ) n_irq++;
        if (STS_BUSY) n_busy++;
    end

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic tick();
        @(posedge SYS_CLK);
        #1;
    endtask

    task automatic start_job(input int nfft, input int fwd, input int scale, input int frames);
        CTL_NFFT    = 5'(nfft);
        CTL_FWD_INV = 1'(fwd);
        CTL_SCALE   = SCALE_W'(scale);
        CTL_FRAMES  = 16'(frames);
        CTL_GO      = 1'b1;
        tick();
        CTL_GO      = 1'b0;
    endtask

    task automatic cfg_handshake(input int low, input logic [CFG_W-1:0] exp_word);
        checks++;
        if (dp.CFG_TVALID !== 1'b1) begin
            errors++;
            $display("[TB] FAIL cfg_valid_entry: got %b, expected 1", dp.CFG_TVALID);
        end
        checks++;
        if (dp.CFG_TDATA !== exp_word) begin
            errors++;
            $display("[TB] FAIL cfg_tdata: got %06h, expected %06h", dp.CFG_TDATA, exp_word);
        end
        repeat (low) tick();
        dp.CFG_TREADY = 1'b1;
        tick();
        dp.CFG_TREADY = 1'b0;
    endtask

    // Waits for a launch, then drives done/event pulses at the given WAIT-cycle offsets (-1 = never).
    task automatic serve_frame(input int dm, input int ds, input int eu, input int em);
        int n;
        int last;
        n = 0;
        while (dp.M2S_GO !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (dp.M2S_GO !== 1'b1 || dp.S2M_GO !== 1'b1) begin
            errors++;
            $display("[TB] FAIL launch_pair: got m2s_go=%b s2m_go=%b after %0d cycles, expected 1 1", dp.M2S_GO, dp.S2M_GO, n);
        end
        tick();
        last = max2(max2(dm, ds), max2(eu, em));
        for (int c = 0; c <= last; c++) begin
            dp.M2S_DONE             = (c == dm);
            dp.S2M_DONE             = (c == ds);
            dp.EVT_TLAST_UNEXPECTED = (c == eu);
            dp.EVT_TLAST_MISSING    = (c == em);
            tick();
        end
        dp.M2S_DONE             = 1'b0;
        dp.S2M_DONE             = 1'b0;
        dp.EVT_TLAST_UNEXPECTED = 1'b0;
        dp.EVT_TLAST_MISSING    = 1'b0;
    endtask

    task automatic test_reset();
        SYS_RST_N = 1'b0;
        #12;
        checks++;
        if ({STS_BUSY, STS_DONE, STS_ERR, STS_ERR_CODE, STS_FRAME_CNT, IRQ,
             dp.CFG_TVALID, dp.CFG_TDATA, dp.M2S_GO, dp.S2M_GO} !== 50'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got busy=%b done=%b err=%b code=%0d cnt=%0d irq=%b tvalid=%b tdata=%h go=%b%b, expected all 0",
                     STS_BUSY, STS_DONE, STS_ERR, STS_ERR_CODE, STS_FRAME_CNT, IRQ, dp.CFG_TVALID, dp.CFG_TDATA, dp.M2S_GO, dp.S2M_GO);
        end
        @(negedge SYS_CLK);
        SYS_RST_N = 1'b1;
        tick();
    endtask

    task automatic test_single_frame();
        int v0, m0;
        logic [CFG_W-1:0] w;
        w  = CFG_W'(10 + 1 * 256 + 'h2AB * 512);
        v0 = n_cfg_valid;
        m0 = n_m2s_go;
        start_job(10, 1, 'h2AB, 1);
        checks++;
        if (STS_BUSY !== 1'b1) begin
            errors++;
            $display("[TB] FAIL single_busy: got %b, expected 1", STS_BUSY);
        end
        cfg_handshake(3, w);
        serve_frame(0, 5, -1, -1);
        checks++;
        if ({STS_BUSY, STS_DONE, STS_ERR, IRQ, STS_FRAME_CNT} !== {4'b0101, 16'd1}) begin
            errors++;
            $display("[TB] FAIL single_end: got busy=%b done=%b err=%b irq=%b cnt=%0d, expected 0 1 0 1 1",
                     STS_BUSY, STS_DONE, STS_ERR, IRQ, STS_FRAME_CNT);
        end
        tick();
        checks++;
        if ({IRQ, n_cfg_valid - v0, n_m2s_go - m0} !== {1'b0, 32'd4, 32'd1}) begin
            errors++;
            $display("[TB] FAIL single_counts: got irq=%b tvalid_cycles=%0d launches=%0d, expected 0 4 1",
                     IRQ, n_cfg_valid - v0, n_m2s_go - m0);
        end
    endtask

    task automatic test_random_runs(input int runs);
        int nfft, fwd, scale, frames, low, err_frame, kind, dm, ds, e;
        int v0, h0, m0, s0, i0;
        int exp_launch, exp_cnt, exp_code;
        logic exp_err;
        for (int r = 0; r < runs; r++) begin
            nfft      = $urandom_range(3, 10);
            fwd       = $urandom_range(0, 1);
            scale     = $urandom_range(0, 1023);
            frames    = $urandom_range(1, 4);
            low       = $urandom_range(0, 3);
            err_frame = ($urandom_range(0, 2) == 0) ? $urandom_range(0, frames - 1) : frames;
            kind      = $urandom_range(1, 3);
            v0 = n_cfg_valid; h0 = n_cfg_hs; m0 = n_m2s_go; s0 = n_s2m_go; i0 = n_irq;
            start_job(nfft, fwd, scale, frames);
            cfg_handshake(low, CFG_W'(nfft + fwd * 256 + scale * 512));
            for (int f = 0; f < frames && f <= err_frame; f++) begin
                dm = $urandom_range(0, 4);
                ds = $urandom_range(0, 4);
                if (f == err_frame) begin
                    e = $urandom_range(0, max2(dm, ds));
                    serve_frame(dm, ds, (kind & 1) ? e : -1, (kind & 2) ? e : -1);
                end else begin
                    serve_frame(dm, ds, -1, -1);
                end
            end
            tick();
            exp_err    = (err_frame < frames);
            exp_launch = exp_err ? err_frame + 1 : frames;
            exp_cnt    = exp_err ? err_frame : frames;
            exp_code   = !exp_err ? 0 : ((kind & 1) ? 1 : 2);
            checks++;
            if ({STS_BUSY, STS_DONE, STS_ERR, STS_ERR_CODE, STS_FRAME_CNT} !==
                {1'b0, !exp_err, exp_err, 3'(exp_code), 16'(exp_cnt)}) begin
                errors++;
                $display("[TB] FAIL random_status run %0d: got busy=%b done=%b err=%b code=%0d cnt=%0d, expected 0 %b %b %0d %0d",
                         r, STS_BUSY, STS_DONE, STS_ERR, STS_ERR_CODE, STS_FRAME_CNT, !exp_err, exp_err, exp_code, exp_cnt);
            end
            checks++;
            if ({n_cfg_valid - v0, n_cfg_hs - h0, n_m2s_go - m0, n_s2m_go - s0, n_irq - i0} !==
                {32'(low + 1), 32'd1, 32'(exp_launch), 32'(exp_launch), 32'd1}) begin
                errors++;
                $display("[TB] FAIL random_counts run %0d: got tvalid=%0d hs=%0d m2s=%0d s2m=%0d irq=%0d, expected %0d 1 %0d %0d 1",
                         r, n_cfg_valid - v0, n_cfg_hs - h0, n_m2s_go - m0, n_s2m_go - s0, n_irq - i0, low + 1, exp_launch, exp_launch);
            end
        end
    endtask

    task automatic test_back_to_back();
        int h0, m0, s0, i0, d;
        h0 = n_cfg_hs; m0 = n_m2s_go; s0 = n_s2m_go; i0 = n_irq;
        start_job(6, 0, 'h155, 3);
        cfg_handshake(0, CFG_W'(6 + 'h155 * 512));
        for (int f = 0; f < 3; f++) begin
            d = $urandom_range(0, 3);
            serve_frame(d, d, -1, -1);
        end
        repeat (2) tick();
        checks++;
        if ({STS_DONE, STS_ERR, STS_FRAME_CNT, n_cfg_hs - h0, n_m2s_go - m0, n_s2m_go - s0, n_irq - i0} !==
            {2'b10, 16'd3, 32'd1, 32'd3, 32'd3, 32'd1}) begin
            errors++;
            $display("[TB] FAIL back_to_back: got done=%b err=%b cnt=%0d hs=%0d m2s=%0d s2m=%0d irq=%0d, expected 1 0 3 1 3 3 1",
                     STS_DONE, STS_ERR, STS_FRAME_CNT, n_cfg_hs - h0, n_m2s_go - m0, n_s2m_go - s0, n_irq - i0);
        end
    endtask

    task automatic test_bad_args();
        int nf [4];
        int fr [4];
        int v0, m0, b0, i0;
        nf[0] = 2; nf[1] = 11; nf[2] = 5; nf[3] = $urandom_range(0, 1) ? $urandom_range(0, 2) : $urandom_range(11, 31);
        fr[0] = 1; fr[1] = 1;  fr[2] = 0; fr[3] = $urandom_range(1, 100);
        for (int k = 0; k < 4; k++) begin
            v0 = n_cfg_valid; m0 = n_m2s_go; b0 = n_busy; i0 = n_irq;
            start_job(nf[k], 1, 3, fr[k]);
            checks++;
            if ({STS_ERR, STS_ERR_CODE, IRQ, STS_BUSY, STS_DONE} !== 7'b1_011_1_0_0) begin
                errors++;
                $display("[TB] FAIL bad_args nfft=%0d frames=%0d: got err=%b code=%0d irq=%b busy=%b done=%b, expected 1 3 1 0 0",
                         nf[k], fr[k], STS_ERR, STS_ERR_CODE, IRQ, STS_BUSY, STS_DONE);
            end
            repeat (3) tick();
            checks++;
            if ({n_cfg_valid - v0, n_m2s_go - m0, n_busy - b0, n_irq - i0} !== {32'd0, 32'd0, 32'd0, 32'd1}) begin
                errors++;
                $display("[TB] FAIL bad_args_quiet nfft=%0d: got tvalid=%0d go=%0d busy=%0d irq=%0d, expected 0 0 0 1",
                         nf[k], n_cfg_valid - v0, n_m2s_go - m0, n_busy - b0, n_irq - i0);
            end
        end
    endtask

    task automatic test_event_error();
        int m0, i0;
        m0 = n_m2s_go; i0 = n_irq;
        start_job(9, 1, 0, 4);
        cfg_handshake(1, CFG_W'(9 + 256));
        serve_frame(1, 1, -1, -1);
        serve_frame(0, 2, 2, 2);
        checks++;
        if ({STS_BUSY, STS_DONE, STS_ERR, STS_ERR_CODE, STS_FRAME_CNT, IRQ} !== {3'b001, 3'd1, 16'd1, 1'b1}) begin
            errors++;
            $display("[TB] FAIL evt_both: got busy=%b done=%b err=%b code=%0d cnt=%0d irq=%b, expected 0 0 1 1 1 1",
                     STS_BUSY, STS_DONE, STS_ERR, STS_ERR_CODE, STS_FRAME_CNT, IRQ);
        end
        repeat (2) tick();
        checks++;
        if ({n_m2s_go - m0, n_irq - i0} !== {32'd2, 32'd1}) begin
            errors++;
            $display("[TB] FAIL evt_both_counts: got launches=%0d irq=%0d, expected 2 1", n_m2s_go - m0, n_irq - i0);
        end
        start_job(4, 0, 1, 2);
        cfg_handshake(0, CFG_W'(4 + 512));
        serve_frame(3, 3, -1, 1);
        tick();
        checks++;
        if ({STS_DONE, STS_ERR, STS_ERR_CODE, STS_FRAME_CNT} !== {2'b01, 3'd2, 16'd0}) begin
            errors++;
            $display("[TB] FAIL evt_missing: got done=%b err=%b code=%0d cnt=%0d, expected 0 1 2 0",
                     STS_DONE, STS_ERR, STS_ERR_CODE, STS_FRAME_CNT);
        end
    endtask

    task automatic test_abort();
        int v0, h0, m0, i0;
        i0 = n_irq;
        start_job(7, 0, 9, 2);
        tick();
        CTL_ABORT = 1'b1;
        tick();
        CTL_ABORT = 1'b0;
        checks++;
        if ({dp.CFG_TVALID, STS_BUSY, IRQ} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL abort_cfg: got tvalid=%b busy=%b irq=%b, expected 0 0 0", dp.CFG_TVALID, STS_BUSY, IRQ);
        end
        tick();
        v0 = n_cfg_valid; h0 = n_cfg_hs; m0 = n_m2s_go;
        start_job(8, 1, 20, 3);
        cfg_handshake(1, CFG_W'(8 + 256 + 20 * 512));
        tick();
        CTL_GO = 1'b1;
        tick();
        CTL_GO = 1'b0;
        tick();
        CTL_ABORT = 1'b1;
        tick();
        CTL_ABORT = 1'b0;
        checks++;
        if ({STS_BUSY, dp.M2S_GO, dp.S2M_GO} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL abort_wait: got busy=%b go=%b%b, expected 0 00", STS_BUSY, dp.M2S_GO, dp.S2M_GO);
        end
        repeat (3) tick();
        checks++;
        if ({STS_DONE, STS_ERR, STS_ERR_CODE, STS_FRAME_CNT, n_irq - i0, n_cfg_valid - v0, n_cfg_hs - h0, n_m2s_go - m0} !==
            {2'b00, 3'd0, 16'd0, 32'd0, 32'd2, 32'd1, 32'd1}) begin
            errors++;
            $display("[TB] FAIL abort_aftermath: got done=%b err=%b code=%0d cnt=%0d irq=%0d tvalid=%0d hs=%0d launches=%0d, expected 0 0 0 0 0 2 1 1",
                     STS_DONE, STS_ERR, STS_ERR_CODE, STS_FRAME_CNT, n_irq - i0, n_cfg_valid - v0, n_cfg_hs - h0, n_m2s_go - m0);
        end
        v0 = n_cfg_valid;
        CTL_GO    = 1'b1;
        CTL_ABORT = 1'b1;
        tick();
        CTL_GO    = 1'b0;
        CTL_ABORT = 1'b0;
        repeat (2) tick();
        checks++;
        if ({STS_BUSY, n_cfg_valid - v0} !== {1'b0, 32'd0}) begin
            errors++;
            $display("[TB] FAIL abort_idle_go: got busy=%b tvalid=%0d, expected 0 0", STS_BUSY, n_cfg_valid - v0);
        end
    endtask

`ifdef XFFT_FRAME_SEQUENCER_TIMEOUT_EN
    task automatic test_timeout();
        int k;
        CTL_TIMEOUT = 24'd16;
        start_job(8, 0, 0, 1);
        cfg_handshake(0, CFG_W'(8));
        CTL_TIMEOUT = 24'd0;
        k = 0;
        tick();
        k = 1;
        dp.M2S_DONE = 1'b1;
        tick();
        dp.M2S_DONE = 1'b0;
        k = 2;
        while (STS_ERR !== 1'b1 && k < 40) begin
            tick();
            k++;
        end
        checks++;
        if ({32'(k), STS_ERR_CODE, IRQ, STS_DONE, STS_FRAME_CNT} !== {32'd17, 3'd4, 1'b1, 1'b0, 16'd0}) begin
            errors++;
            $display("[TB] FAIL timeout: got err after %0d cycles code=%0d irq=%b done=%b cnt=%0d, expected 17 4 1 0 0",
                     k, STS_ERR_CODE, IRQ, STS_DONE, STS_FRAME_CNT);
        end
    endtask
`endif

    task automatic test_reset_mid_wait();
        start_job(5, 1, 7, 2);
        cfg_handshake(0, CFG_W'(5 + 256 + 7 * 512));
        tick();
        dp.M2S_DONE = 1'b1;
        tick();
        dp.M2S_DONE = 1'b0;
        checks++;
        if (STS_BUSY !== 1'b1) begin
            errors++;
            $display("[TB] FAIL pre_reset_busy: got %b, expected 1", STS_BUSY);
        end
        #2;
        SYS_RST_N = 1'b0;
        #1;
        checks++;
        if ({STS_BUSY, STS_DONE, STS_ERR, STS_ERR_CODE, STS_FRAME_CNT, IRQ,
             dp.CFG_TVALID, dp.CFG_TDATA, dp.M2S_GO, dp.S2M_GO} !== 50'd0) begin
            errors++;
            $display("[TB] FAIL async_reset: got busy=%b done=%b err=%b code=%0d cnt=%0d irq=%b tvalid=%b tdata=%h go=%b%b, expected all 0",
                     STS_BUSY, STS_DONE, STS_ERR, STS_ERR_CODE, STS_FRAME_CNT, IRQ, dp.CFG_TVALID, dp.CFG_TDATA, dp.M2S_GO, dp.S2M_GO);
        end
        @(negedge SYS_CLK);
        SYS_RST_N = 1'b1;
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL global_timeout: simulation still running at %0t, expected completion", $time);
        $fatal(1, "[TB] bench did not finish");
    end

    initial begin
        dp.CFG_TREADY           = 1'b0;
        dp.M2S_DONE             = 1'b0;
        dp.S2M_DONE             = 1'b0;
        dp.EVT_TLAST_UNEXPECTED = 1'b0;
        dp.EVT_TLAST_MISSING    = 1'b0;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_random_runs(10);
        test_bad_args();
        test_event_error();
        test_abort();
`ifdef XFFT_FRAME_SEQUENCER_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
